// File: rtl/mux_scan_pkg.sv
// Shared types, sizes and the channel-to-select mapping for the mux scan sequencer.
package mux_scan_pkg;

    localparam int CH_COUNT = 16;
    localparam int CH_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Channel index to {sel0, sel1, sel2, sel3}: sel0..sel2 carry the in-half index
    // MSB-first, sel3 picks the lower half (channels 0..7) when high.
    function automatic logic [3:0] ch_to_sel(input logic [CH_W-1:0] ch);
        ch_to_sel = {ch[2], ch[1], ch[0], ~ch[3]};
    endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Priority finder: next set mask bit strictly above idx, or lowest set bit when from_start.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [CH_COUNT-1:0] mask,
    input  logic [CH_W-1:0]     idx,
    input  logic                from_start,
    output logic [CH_W-1:0]     next_ch,
    output logic                found
);

    // Walk from the top down so the lowest qualifying channel is the last one written
    always_comb begin
        next_ch = {CH_W{1'b0}};
        found   = 1'b0;
        for (int i = CH_COUNT - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (CH_W'(i) > idx))) begin
                next_ch = CH_W'(i);
                found   = 1'b1;
            end else begin
                next_ch = next_ch;
                found   = found;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 16:1 mux selects through a masked channel set, samples the mux output
// once per channel after a settle time, and returns the assembled word over valid/ready.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [CH_COUNT-1:0] ch_mask,
    output logic                sel0,
    output logic                sel1,
    output logic                sel2,
    output logic                sel3,
    input  logic                mux_s,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [CH_COUNT-1:0] result,
    output logic                busy
);

    // A settle time of zero would never sample, so it is promoted to one cycle.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);

    state_t                state_r;
    logic [CH_COUNT-1:0]   mask_r;
    logic [CH_W-1:0]       ch_r;
    logic [CNT_W-1:0]      settle_r;
    logic [3:0]            sel_r;
    logic [CH_COUNT-1:0]   result_r;
    logic                  start_ready_r;
    logic                  result_valid_r;
    logic                  busy_r;

    logic [CH_COUNT-1:0]   find_mask_s;
    logic                  find_from_start_s;
    logic [CH_W-1:0]       next_ch_s;
    logic                  found_s;
    logic                  settle_done_s;

    // In IDLE search the incoming mask from the bottom; otherwise continue above the current channel
    always_comb begin
        find_mask_s       = mask_r;
        find_from_start_s = 1'b0;
        if (state_r == IDLE) begin
            find_mask_s       = ch_mask;
            find_from_start_s = 1'b1;
        end else begin
            find_mask_s       = mask_r;
            find_from_start_s = 1'b0;
        end
    end

    // Flag the last cycle of the settle window for the current channel
    always_comb begin
        settle_done_s = (settle_r == SETTLE_LAST);
    end

    mux_scan_next_ch u_next_ch (
        .mask       (find_mask_s),
        .idx        (ch_r),
        .from_start (find_from_start_s),
        .next_ch    (next_ch_s),
        .found      (found_s)
    );

    // Scan controller: request acceptance, channel stepping, sampling and result handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            mask_r         <= {CH_COUNT{1'b0}};
            ch_r           <= {CH_W{1'b0}};
            settle_r       <= {CNT_W{1'b0}};
            sel_r          <= ch_to_sel(4'd0);
            result_r       <= {CH_COUNT{1'b0}};
            start_ready_r  <= 1'b1;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        mask_r        <= ch_mask;
                        result_r      <= {CH_COUNT{1'b0}};
                        start_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        if (found_s) begin
                            ch_r     <= next_ch_s;
                            sel_r    <= ch_to_sel(next_ch_s);
                            settle_r <= {CNT_W{1'b0}};
                            state_r  <= SCAN;
                        end else begin
                            // Empty mask: valid is raised one cycle later from DONE.
                            state_r  <= DONE;
                        end
                    end else begin
                        start_ready_r <= 1'b1;
                    end
                end

                SCAN: begin
                    if (settle_done_s) begin
                        result_r[ch_r] <= mux_s;
                        if (found_s) begin
                            ch_r     <= next_ch_s;
                            sel_r    <= ch_to_sel(next_ch_s);
                            settle_r <= {CNT_W{1'b0}};
                        end else begin
                            // Selects keep pointing at the last visited channel.
                            result_valid_r <= 1'b1;
                            state_r        <= DONE;
                        end
                    end else begin
                        settle_r <= settle_r + CNT_W'(1);
                    end
                end

                DONE: begin
                    if (!result_valid_r) begin
                        result_valid_r <= 1'b1;
                    end else if (result_ready) begin
                        // Result word stays readable until the next start clears it.
                        result_valid_r <= 1'b0;
                        busy_r         <= 1'b0;
                        start_ready_r  <= 1'b1;
                        state_r        <= IDLE;
                    end else begin
                        result_valid_r <= 1'b1;
                    end
                end

                default: begin
                    state_r        <= IDLE;
                    start_ready_r  <= 1'b1;
                    result_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    assign sel0         = sel_r[3];
    assign sel1         = sel_r[2];
    assign sel2         = sel_r[1];
    assign sel3         = sel_r[0];
    assign start_ready  = start_ready_r;
    assign result_valid = result_valid_r;
    assign result       = result_r;
    assign busy         = busy_r;

endmodule
